// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write-side logic.
//   H_RES / V_RES : visible raster size in pixels
//   FB_DEPTH      : number of addressable pixels (H_RES*V_RES)
//   ADDR_W        : frame-buffer address width
//   fill_state_e  : fill engine state (idle / filling)
//   grant_e       : owner of the most recent write slot
package fb_pkg;

   localparam int H_RES    = 640;
   localparam int V_RES    = 480;
   localparam int FB_DEPTH = H_RES * V_RES;
   localparam int ADDR_W   = 19;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   typedef enum logic {
      GNT_HOST = 1'b0,
      GNT_FILL = 1'b1
   } grant_e;

endpackage

// File: rtl/fb_rect_addr_gen.sv
// Rectangle walker for the fill engine: clips the requested rectangle to
// the raster, then steps through its pixels in row-major order producing
// linear frame-buffer addresses without a multiplier.
//   iclk, iRST      : clock, synchronous active-high reset
//   iload           : capture ix0/iy0/iw/ih and point at the first pixel
//   istep           : advance to the next pixel
//   ix0, iy0        : rectangle origin
//   iw, ih          : requested rectangle size
//   oempty          : combinational; the rectangle on the inputs clips to nothing
//   oaddr           : address of the current pixel
//   olast           : the current pixel is the final one of the rectangle
module fb_rect_addr_gen #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              iclk,
   input  logic              iRST,
   input  logic              iload,
   input  logic              istep,
   input  logic [9:0]        ix0,
   input  logic [8:0]        iy0,
   input  logic [9:0]        iw,
   input  logic [8:0]        ih,
   output logic              oempty,
   output logic [ADDR_W-1:0] oaddr,
   output logic              olast
);

   logic [10:0]       x_room;
   logic [9:0]        y_room;
   logic [9:0]        w_clip;
   logic [8:0]        h_clip;
   logic [ADDR_W-1:0] row_base_start;

   logic [9:0]        w_eff_q, x_cnt_q;
   logic [8:0]        h_eff_q, y_cnt_q;
   logic [ADDR_W-1:0] row_base_q, addr_q;
   logic              x_last;

   // Room left to the right/bottom edge; only meaningful when the origin is
   // on-screen, which oempty guarantees before anything is loaded.
   assign x_room = 11'(H_RES) - {1'b0, ix0};
   assign y_room = 10'(V_RES) - {1'b0, iy0};
   assign w_clip = ({1'b0, iw} > x_room) ? x_room[9:0] : iw;
   assign h_clip = ({1'b0, ih} > y_room) ? y_room[8:0] : ih;

   assign oempty = ({1'b0, ix0} >= 11'(H_RES)) || ({1'b0, iy0} >= 10'(V_RES)) ||
                   (iw == '0) || (ih == '0);

   // y0*640 as y0*512 + y0*128: two shifted adds instead of a multiplier.
   assign row_base_start = ADDR_W'({iy0, 9'b0}) + ADDR_W'({iy0, 7'b0}) + ADDR_W'(ix0);

   assign x_last = (x_cnt_q == w_eff_q - 10'd1);
   assign olast  = x_last && (y_cnt_q == h_eff_q - 9'd1);
   assign oaddr  = addr_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge iclk) begin
      if (iRST) begin
         w_eff_q    <= '0;
         h_eff_q    <= '0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
      end else if (iload) begin
         w_eff_q    <= w_clip;
         h_eff_q    <= h_clip;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         row_base_q <= row_base_start;
         addr_q     <= row_base_start;
      end else if (istep) begin
         if (x_last) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= y_cnt_q + 9'd1;
            row_base_q <= row_base_q + ADDR_W'(H_RES);
            addr_q     <= row_base_q + ADDR_W'(H_RES);
         end else begin
            x_cnt_q <= x_cnt_q + 10'd1;
            addr_q  <= addr_q + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/fb_fill_arbiter.sv
// Write-side controller for the frame buffer. Shares the single write port
// between a host pixel interface and a rectangle-fill engine, alternating
// grants when both want the slot.
//   iclk, iRST                     : clock, synchronous active-high reset
//   ihost_valid/addr/data          : host pixel write request
//   ohost_ready                    : host request taken when valid && ready
//   ifill_start, ifill_x0/y0/w/h   : fill command strobe and rectangle
//   ifill_color                    : fill colour index
//   ofill_busy                     : fill in progress
//   ofill_done                     : one-cycle completion pulse
//   owren, oaddr, odata            : registered frame-buffer write port
module fb_fill_arbiter #(
   parameter int H_RES  = fb_pkg::H_RES,
   parameter int V_RES  = fb_pkg::V_RES,
   parameter int ADDR_W = fb_pkg::ADDR_W
) (
   input  logic              iclk,
   input  logic              iRST,
   input  logic              ihost_valid,
   input  logic [ADDR_W-1:0] ihost_addr,
   input  logic [7:0]        ihost_data,
   output logic              ohost_ready,
   input  logic              ifill_start,
   input  logic [9:0]        ifill_x0,
   input  logic [8:0]        ifill_y0,
   input  logic [9:0]        ifill_w,
   input  logic [8:0]        ifill_h,
   input  logic [7:0]        ifill_color,
   output logic              ofill_busy,
   output logic              ofill_done,
   output logic              owren,
   output logic [ADDR_W-1:0] oaddr,
   output logic [7:0]        odata
);

   localparam int FB_DEPTH = H_RES * V_RES;

   fb_pkg::fill_state_e state_q, state_d;
   fb_pkg::grant_e      last_grant_q, last_grant_d;
   logic                wren_q, wren_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                done_q, done_d;
   logic [7:0]          color_q, color_d;

   logic                host_fire;
   logic                gen_load, gen_step, gen_empty, gen_last;
   logic [ADDR_W-1:0]   gen_addr;

   fb_rect_addr_gen #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .iclk   (iclk),
      .iRST   (iRST),
      .iload  (gen_load),
      .istep  (gen_step),
      .ix0    (ifill_x0),
      .iy0    (ifill_y0),
      .iw     (ifill_w),
      .ih     (ifill_h),
      .oempty (gen_empty),
      .oaddr  (gen_addr),
      .olast  (gen_last)
   );

   // The host may go whenever no fill is running, or when the fill took the
   // previous slot; this caps the fill at one pixel between host grants.
   assign ohost_ready = (state_q == fb_pkg::ST_IDLE) || (last_grant_q == fb_pkg::GNT_FILL);
   assign host_fire   = ihost_valid && ohost_ready;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wren_d       = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      done_d       = 1'b0;
      color_d      = color_q;
      gen_load     = 1'b0;
      gen_step     = 1'b0;

      if (host_fire) begin
         last_grant_d = fb_pkg::GNT_HOST;
         // Out-of-range host writes are accepted but silently dropped.
         if (ihost_addr < ADDR_W'(FB_DEPTH)) begin
            wren_d = 1'b1;
            addr_d = ihost_addr;
            data_d = ihost_data;
         end
      end else if (state_q == fb_pkg::ST_FILL) begin
         last_grant_d = fb_pkg::GNT_FILL;
         gen_step     = 1'b1;
         wren_d       = 1'b1;
         addr_d       = gen_addr;
         data_d       = color_q;
         if (gen_last) begin
            state_d = fb_pkg::ST_IDLE;
            done_d  = 1'b1;
         end
      end

      // Starts are only honoured while idle; the done cycle is already idle.
      if (state_q == fb_pkg::ST_IDLE && ifill_start) begin
         if (gen_empty) begin
            done_d = 1'b1;
         end else begin
            state_d  = fb_pkg::ST_FILL;
            gen_load = 1'b1;
            color_d  = ifill_color;
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (iRST) begin
         state_q      <= fb_pkg::ST_IDLE;
         last_grant_q <= fb_pkg::GNT_FILL;
         wren_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         done_q       <= 1'b0;
         color_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wren_q       <= wren_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         done_q       <= done_d;
         color_q      <= color_d;
      end
   end

   assign ofill_busy = (state_q == fb_pkg::ST_FILL);
   assign ofill_done = done_q;
   assign owren      = wren_q;
   assign oaddr      = addr_q;
   assign odata      = data_q;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Directed bench for fb_fill_arbiter: host-only writes, unobstructed fill,
// fill under continuous host traffic, clipping, start-while-busy, start in
// the done cycle, and reset mid-fill.
module tb_fb_fill_arbiter;

   localparam int ADDR_W = 19;

   logic              iclk = 1'b0;
   logic              iRST;
   logic              ihost_valid;
   logic [ADDR_W-1:0] ihost_addr;
   logic [7:0]        ihost_data;
   logic              ohost_ready;
   logic              ifill_start;
   logic [9:0]        ifill_x0;
   logic [8:0]        ifill_y0;
   logic [9:0]        ifill_w;
   logic [8:0]        ifill_h;
   logic [7:0]        ifill_color;
   logic              ofill_busy;
   logic              ofill_done;
   logic              owren;
   logic [ADDR_W-1:0] oaddr;
   logic [7:0]        odata;

   int checks   = 0;
   int failures = 0;

   // Expected addresses of the 10,2 / 3x2 rectangle: row base 2*640+10.
   int rect_a [6] = '{1290, 1291, 1292, 1930, 1931, 1932};

   fb_fill_arbiter dut (
      .iclk        (iclk),
      .iRST        (iRST),
      .ihost_valid (ihost_valid),
      .ihost_addr  (ihost_addr),
      .ihost_data  (ihost_data),
      .ohost_ready (ohost_ready),
      .ifill_start (ifill_start),
      .ifill_x0    (ifill_x0),
      .ifill_y0    (ifill_y0),
      .ifill_w     (ifill_w),
      .ifill_h     (ifill_h),
      .ifill_color (ifill_color),
      .ofill_busy  (ofill_busy),
      .ofill_done  (ofill_done),
      .owren       (owren),
      .oaddr       (oaddr),
      .odata       (odata)
   );

   always #5 iclk = ~iclk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic wr, input int addr, input int data);
      check({tag, ".wren"}, 32'(owren), 32'(wr));
      if (wr) begin
         check({tag, ".addr"}, 32'(oaddr), 32'(addr));
         check({tag, ".data"}, 32'(odata), 32'(data));
      end
   endtask

   task automatic check_st(input string tag, input logic busy, input logic done);
      check({tag, ".busy"}, 32'(ofill_busy), 32'(busy));
      check({tag, ".done"}, 32'(ofill_done), 32'(done));
   endtask

   task automatic set_fill(input int x0, input int y0, input int w, input int h, input int col);
      ifill_x0    = 10'(x0);
      ifill_y0    = 9'(y0);
      ifill_w     = 10'(w);
      ifill_h     = 9'(h);
      ifill_color = 8'(col);
   endtask

   initial begin
      iRST        = 1'b1;
      ihost_valid = 1'b0;
      ihost_addr  = '0;
      ihost_data  = '0;
      ifill_start = 1'b0;
      set_fill(0, 0, 0, 0, 0);

      // ---- reset state ----
      tick(); tick(); tick();
      check_wr("rst", 1'b0, 0, 0);
      check("rst.addr", 32'(oaddr), 32'd0);
      check("rst.data", 32'(odata), 32'd0);
      check_st("rst", 1'b0, 1'b0);
      iRST = 1'b0;
      tick();
      check("rst.ready", 32'(ohost_ready), 32'd1);

      // ---- host only ----
      ihost_valid = 1'b1; ihost_addr = 19'd0; ihost_data = 8'h11;
      check("h0.ready", 32'(ohost_ready), 32'd1);
      tick();
      check_wr("h0", 1'b1, 0, 'h11);
      ihost_addr = 19'd307199; ihost_data = 8'h22;
      check("h1.ready", 32'(ohost_ready), 32'd1);
      tick();
      check_wr("h1", 1'b1, 307199, 'h22);
      ihost_addr = 19'd307200; ihost_data = 8'h33;
      check("h2.ready", 32'(ohost_ready), 32'd1);
      tick();
      check_wr("h2_dropped", 1'b0, 0, 0);
      ihost_valid = 1'b0;
      tick();
      check_wr("h_idle", 1'b0, 0, 0);

      // ---- fill, host idle ----
      set_fill(10, 2, 3, 2, 'h5A);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_wr("fa.start", 1'b0, 0, 0);
      check_st("fa.start", 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_wr($sformatf("fa.px%0d", i), 1'b1, rect_a[i], 'h5A);
         check_st($sformatf("fa.px%0d", i), i < 5, i == 5);
      end
      tick();
      check_wr("fa.after", 1'b0, 0, 0);
      check_st("fa.after", 1'b0, 1'b0);

      // ---- same fill with continuous host traffic ----
      set_fill(10, 2, 3, 2, 'h77);
      ihost_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         ihost_addr  = 19'(100 + c / 2);
         ihost_data  = 8'('hC0 + c / 2);
         ifill_start = (c == 0);
         check($sformatf("ct.ready%0d", c), 32'(ohost_ready), 32'((c % 2) == 0));
         tick();
         ifill_start = 1'b0;
         if ((c % 2) == 0)
            check_wr($sformatf("ct.host%0d", c), 1'b1, 100 + c / 2, 'hC0 + c / 2);
         else
            check_wr($sformatf("ct.fill%0d", c), 1'b1, rect_a[(c - 1) / 2], 'h77);
         check_st($sformatf("ct.c%0d", c), c < 11, c == 11);
      end
      ihost_valid = 1'b0;
      tick();
      check_wr("ct.after", 1'b0, 0, 0);
      check_st("ct.after", 1'b0, 1'b0);

      // ---- clipping at bottom-right corner ----
      set_fill(638, 479, 5, 5, 'h44);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_st("clip.start", 1'b1, 1'b0);
      tick();
      check_wr("clip.px0", 1'b1, 307198, 'h44);
      check_st("clip.px0", 1'b1, 1'b0);
      tick();
      check_wr("clip.px1", 1'b1, 307199, 'h44);
      check_st("clip.px1", 1'b0, 1'b1);
      tick();
      check_wr("clip.after", 1'b0, 0, 0);
      check_st("clip.after", 1'b0, 1'b0);

      // ---- empty fills: w=0, then origin off-screen ----
      set_fill(0, 0, 0, 3, 'h55);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_wr("w0", 1'b0, 0, 0);
      check_st("w0", 1'b0, 1'b1);
      tick();
      check_wr("w0.after", 1'b0, 0, 0);
      check_st("w0.after", 1'b0, 1'b0);
      set_fill(700, 0, 4, 4, 'h55);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_wr("xoff", 1'b0, 0, 0);
      check_st("xoff", 1'b0, 1'b1);

      // ---- start while busy is ignored; start in done cycle is taken ----
      set_fill(0, 0, 4, 1, 'h12);
      ifill_start = 1'b1;
      tick();
      set_fill(5, 5, 2, 2, 'h99);
      tick();
      check_wr("sb.px0", 1'b1, 0, 'h12);
      tick();
      ifill_start = 1'b0;
      check_wr("sb.px1", 1'b1, 1, 'h12);
      tick();
      check_wr("sb.px2", 1'b1, 2, 'h12);
      tick();
      check_wr("sb.px3", 1'b1, 3, 'h12);
      check_st("sb.px3", 1'b0, 1'b1);
      set_fill(1, 1, 1, 1, 'h21);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_wr("dc.start", 1'b0, 0, 0);
      check_st("dc.start", 1'b1, 1'b0);
      tick();
      check_wr("dc.px0", 1'b1, 641, 'h21);
      check_st("dc.px0", 1'b0, 1'b1);

      // ---- reset mid-fill ----
      set_fill(0, 10, 8, 1, 'h66);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      tick();
      check_wr("rm.px0", 1'b1, 6400, 'h66);
      tick();
      check_wr("rm.px1", 1'b1, 6401, 'h66);
      iRST = 1'b1;
      tick();
      check_wr("rm.rst", 1'b0, 0, 0);
      check_st("rm.rst", 1'b0, 1'b0);
      iRST = 1'b0;
      tick();
      check_wr("rm.rel", 1'b0, 0, 0);
      check_st("rm.rel", 1'b0, 1'b0);
      set_fill(1, 0, 2, 1, 'h0F);
      ifill_start = 1'b1;
      tick();
      ifill_start = 1'b0;
      check_st("rm.new", 1'b1, 1'b0);
      tick();
      check_wr("rm.new0", 1'b1, 1, 'h0F);
      tick();
      check_wr("rm.new1", 1'b1, 2, 'h0F);
      check_st("rm.new1", 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_fill_arbiter.md
# fb_fill_arbiter

Write-side controller for the 640x480, 8-bit-index dual-port frame buffer. It shares the buffer's single write port between a host pixel-write interface and an internal rectangle-fill engine, using round-robin alternation under contention. It sits in the write-clock domain in front of the frame buffer's write port (wraddress/wren/data); the VGA read side is untouched.

## Interface
Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, frame-buffer address width

Ports:
- iclk  in  1  write-domain clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- ihost_valid  in  1  host write request
- ihost_addr  in  ADDR_W  linear pixel address (y*H_RES + x)
- ihost_data  in  8  colour index
- ohost_ready  out  1  host request accepted when valid && ready
- ifill_start  in  1  fill command strobe
- ifill_x0 / ifill_y0  in  10 / 9  rectangle origin
- ifill_w / ifill_h  in  10 / 9  rectangle size in pixels
- ifill_color  in  8  fill colour index
- ofill_busy  out  1  fill in progress
- ofill_done  out  1  one-cycle completion pulse
- owren / oaddr / odata  out  1 / ADDR_W / 8  frame-buffer write port, registered

## Operation
- States: IDLE, FILL.
- IDLE: ifill_start captures the command.
  - Clip the rectangle: w_eff = min(w, H_RES-x0) and h_eff = min(h, V_RES-y0). The result is empty if x0>=H_RES, y0>=V_RES, w=0 or h=0.
  - If non-empty: go to FILL and set busy. If empty: stay in IDLE and pulse done next cycle with no write.
- FILL: emits pixels in row-major order, x increasing.
  - Address is computed incrementally. The start row base is (y0<<9)+(y0<<7)+x0; the row base advances by H_RES per line. No multiplier.
- Arbitration uses a last_grant flag. ohost_ready = !busy || last_grant==FILL.
  - A host transfer (valid && ready) takes the write slot and sets last_grant=HOST.
  - Otherwise, when busy, the fill engine issues one pixel and sets last_grant=FILL.
  - The host is never starved: at most one fill pixel between host grants. The fill pixel rate is at least 1/2 under continuous host traffic, and 1 pixel/cycle when the host is idle.
- A host transfer with ihost_addr >= H_RES*V_RES is accepted (ready honoured) and dropped: owren stays 0.
- ifill_start while busy is ignored. ifill_start in the done cycle is accepted.
- Reset mid-fill aborts the fill: no done pulse and no further writes.

## Timing
- Reset values: owren=0, oaddr=0, odata=0, ofill_busy=0, ofill_done=0, last_grant=FILL. ohost_ready becomes 1 once reset is released.
- Host accepted in cycle N -> owren=1 with its addr/data in cycle N+1.
- Fill start accepted in cycle N:
  - ofill_busy=1 from N+1.
  - The first pixel is granted at the earliest in N+1, and its owren appears in N+2.
- Last fill pixel granted in cycle M: ofill_busy=0 and ofill_done=1 in M+1, together with that pixel's owren.
- Empty fill started in cycle N: ofill_done=1 in N+1, with ofill_busy remaining 0.
- At most one write per cycle. owren is never asserted for an out-of-range address.

## Structure
- Shared package fb_pkg holds:
  - H_RES, V_RES, FB_DEPTH=H_RES*V_RES, ADDR_W
  - the state enum {IDLE, FILL}
  - the grant enum {HOST, FILL}
- One sub-module, fb_rect_addr_gen, holds the clipping, the x/y counters and the row-base address, with a step/last interface. The arbiter and output registers live in the top level.

## Test plan
- Host-only: writes to addr 0, 307199 and 307200 with data 0x11, 0x22, 0x33 -> owren one cycle after each accept for the first two; no write for 307200; ready stays 1.
- Fill x0=10, y0=2, w=3, h=2, colour 0x5A, host idle -> six writes at 1290, 1291, 1292, 1930, 1931, 1932 on consecutive cycles; done with the last write; busy high for 6 cycles.
- Contention: continuous host valid during the same fill -> host and fill writes strictly alternate; fill completes in 12 grant cycles; every host request accepted within 1 cycle.
- Clipping: x0=638, y0=479, w=5, h=5 -> exactly 2 writes (307198, 307199), then done. Also w=0 -> done after 1 cycle with no writes.
- Start while busy with a different colour -> ignored; only the original rectangle is written.
- iRST asserted mid-fill after 2 pixels -> the following cycle owren=0, busy=0, no done; a new fill after release runs normally.
